accu: RTL and testbench



---
 rtl/accu.sv | 66 ++++++
 tb/tb_accu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accu.sv
// -----------------------------------------------------------------------------
// accu -- registered running-sum accumulator
//
// Adds the unsigned sample on `in` to the stored total on every rising edge of
// clk and presents the new total on `acc` (one cycle latency, straight from a
// flop). `ovf` is a sticky flag that records any carry out of the WIDTH-bit sum
// and is cleared only by reset.
//
// Parameters
//   WIDTH     bit width of in and acc
//   SATURATE  0 = sum wraps modulo 2^WIDTH, 1 = sum clamps at 2^WIDTH-1
//
// Ports (positional order is fixed: in, acc, clk, reset, ovf)
//   in     input  [WIDTH-1:0]  unsigned sample, added every cycle
//   acc    output [WIDTH-1:0]  registered running sum
//   clk    input               clock, rising edge
//   reset  input               asynchronous, active-low reset
//   ovf    output              sticky overflow flag
// -----------------------------------------------------------------------------
module accu #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] acc,
    input  logic             clk,
    input  logic             reset,
    output logic             ovf
);

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic [WIDTH:0]   sum;

    // One extra bit so the carry out is the overflow indication.
    assign sum = {1'b0, acc_reg} + {1'b0, in};

    // The wrap/clamp choice is fixed at elaboration, so only one of the two
    // result paths is ever built.
    generate
        if (SATURATE != 0) begin : g_sat
            assign acc_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end else begin : g_wrap
            assign acc_next = sum[WIDTH-1:0];
        end
    endgenerate

    // Carry out is recorded in both modes; once set it stays set.
    assign ovf_next = ovf_reg | sum[WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
        end
    end

    assign acc = acc_reg;
    assign ovf = ovf_reg;

endmodule

// File: tb/tb_accu.sv
// -----------------------------------------------------------------------------
// tb_accu -- self-checking bench for accu
//
// Two instances share clock, reset and stimulus: one wrapping (SATURATE=0) and
// one clamping (SATURATE=1). A reference model computes the expected state of
// both at the moment each sample is driven and pushes it to a scoreboard queue;
// the entry is popped and compared just after the clock edge that consumes
// that sample.
// -----------------------------------------------------------------------------
module tb_accu;

    logic       clk;
    logic       reset;
    logic [7:0] in;
    logic [7:0] acc_w;
    logic       ovf_w;
    logic [7:0] acc_s;
    logic       ovf_s;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [7:0] aw;
        logic       ow;
        logic [7:0] as;
        logic       os;
    } exp_t;

    exp_t sb[$];

    // reference model state
    logic [7:0] m_aw;
    logic       m_ow;
    logic [7:0] m_as;
    logic       m_os;

    accu #(.WIDTH(8), .SATURATE(0)) u_wrap (
        .in   (in),
        .acc  (acc_w),
        .clk  (clk),
        .reset(reset),
        .ovf  (ovf_w)
    );

    accu #(.WIDTH(8), .SATURATE(1)) u_sat (
        .in   (in),
        .acc  (acc_s),
        .clk  (clk),
        .reset(reset),
        .ovf  (ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample, advance the model, push the expectation, then wait
    // until just after the edge that consumes the sample.
    task automatic apply(input logic [7:0] v);
        logic [8:0] sw;
        logic [8:0] ss;
        in = v;
        sw = {1'b0, m_aw} + {1'b0, v};
        ss = {1'b0, m_as} + {1'b0, v};
        m_aw = sw[7:0];
        m_ow = m_ow | sw[8];
        m_as = ss[8] ? 8'hFF : ss[7:0];
        m_os = m_os | ss[8];
        sb.push_back('{aw: m_aw, ow: m_ow, as: m_as, os: m_os});
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_aw = 8'd0;
        m_ow = 1'b0;
        m_as = 8'd0;
        m_os = 1'b0;
    endtask

    // Reset pulse away from the active edge; released 1 ns after an edge.
    task automatic do_reset();
        in = 8'd0;
        #2;
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t got, exp;
        reset = 1'b0;
        in    = 'x;
        model_clear();
        #1;
        vectors++;
        if ({acc_w, ovf_w, acc_s, ovf_s} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_t0: got acc_w=%0d ovf_w=%b acc_s=%0d ovf_s=%b, want all 0",
                     acc_w, ovf_w, acc_s, ovf_s);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({acc_w, ovf_w, acc_s, ovf_s} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_hold: got acc_w=%0d ovf_w=%b acc_s=%0d ovf_s=%b, want all 0",
                     acc_w, ovf_w, acc_s, ovf_s);
        end
        in    = 8'd0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(8'd0);
            got = {acc_w, ovf_w, acc_s, ovf_s};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp || got !== 18'd0) begin
                miscompares++;
                $display("FAIL reset_release in=0 step %0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_accumulate();
        exp_t got, exp;
        logic [7:0] want [3];
        want[0] = 8'd5;
        want[1] = 8'd10;
        want[2] = 8'd15;
        for (int i = 0; i < 3; i++) begin
            apply(8'd5);
            got = {acc_w, ovf_w, acc_s, ovf_s};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp || acc_w !== want[i] || ovf_w !== 1'b0) begin
                miscompares++;
                $display("FAIL accumulate in=5 step %0d: got acc_w=%0d ovf_w=%b (%h) want acc=%0d ovf=0 (%h)",
                         i, acc_w, ovf_w, got, want[i], exp);
            end
        end
    endtask

    task automatic test_wrap_saturate();
        exp_t got, exp;
        logic [7:0] seq [4];
        seq[0] = 8'd250;
        seq[1] = 8'd10;
        seq[2] = 8'd0;
        seq[3] = 8'd1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(seq[i]);
            got = {acc_w, ovf_w, acc_s, ovf_s};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL wrap_sat in=%0d: got acc_w=%0d ovf_w=%b acc_s=%0d ovf_s=%b want acc_w=%0d ovf_w=%b acc_s=%0d ovf_s=%b",
                         seq[i], acc_w, ovf_w, acc_s, ovf_s, exp.aw, exp.ow, exp.as, exp.os);
            end
        end
        // spot checks of the documented boundary values
        vectors++;
        if (acc_w !== 8'd5 || ovf_w !== 1'b1 || acc_s !== 8'd255 || ovf_s !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_sat_final: got acc_w=%0d ovf_w=%b acc_s=%0d ovf_s=%b want 5 1 255 1",
                     acc_w, ovf_w, acc_s, ovf_s);
        end
    endtask

    task automatic test_exact_max();
        exp_t got, exp;
        logic [7:0] seq [3];
        seq[0] = 8'd200;
        seq[1] = 8'd55;
        seq[2] = 8'd0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(seq[i]);
            got = {acc_w, ovf_w, acc_s, ovf_s};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp || (i > 0 && (acc_w !== 8'd255 || ovf_w !== 1'b0 || ovf_s !== 1'b0))) begin
                miscompares++;
                $display("FAIL exact_max in=%0d: got acc_w=%0d ovf_w=%b acc_s=%0d ovf_s=%b want %0d %b %0d %b",
                         seq[i], acc_w, ovf_w, acc_s, ovf_s, exp.aw, exp.ow, exp.as, exp.os);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t got, exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(8'd5);
            got = {acc_w, ovf_w, acc_s, ovf_s};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL async_preload step %0d: got %h want %h", i, got, exp);
            end
        end
        // mid-cycle reset assertion: must clear without a clock edge
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        vectors++;
        if ({acc_w, ovf_w, acc_s, ovf_s} !== 18'd0) begin
            miscompares++;
            $display("FAIL async_clear: got acc_w=%0d acc_s=%0d want 0 before edge", acc_w, acc_s);
        end
        in = 8'd7;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({acc_w, ovf_w, acc_s, ovf_s} !== 18'd0) begin
            miscompares++;
            $display("FAIL async_hold: got acc_w=%0d acc_s=%0d want 0 while reset low", acc_w, acc_s);
        end
        reset = 1'b1;
        apply(8'd3);
        got = {acc_w, ovf_w, acc_s, ovf_s};
        exp = sb.pop_front();
        vectors++;
        if (got !== exp || acc_w !== 8'd3) begin
            miscompares++;
            $display("FAIL async_release in=3: got acc_w=%0d acc_s=%0d want 3 3", acc_w, acc_s);
        end
    endtask

    task automatic test_ramp();
        exp_t got, exp;
        int unsigned tri_sum;
        do_reset();
        for (int i = 0; i <= 128; i++) begin
            apply(8'(i));
            got = {acc_w, ovf_w, acc_s, ovf_s};
            exp = sb.pop_front();
            tri_sum = (i * (i + 1) / 2) % 256;
            vectors++;
            if (got !== exp || acc_w !== 8'(tri_sum)) begin
                miscompares++;
                $display("FAIL ramp i=%0d: got acc_w=%0d ovf_w=%b acc_s=%0d ovf_s=%b want acc_w=%0d ovf_w=%b acc_s=%0d ovf_s=%b",
                         i, acc_w, ovf_w, acc_s, ovf_s, tri_sum, exp.ow, exp.as, exp.os);
            end
        end
        vectors++;
        if (acc_w !== 8'd64 || acc_s !== 8'd255 || ovf_w !== 1'b1) begin
            miscompares++;
            $display("FAIL ramp_final: got acc_w=%0d acc_s=%0d ovf_w=%b want 64 255 1",
                     acc_w, acc_s, ovf_w);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_accumulate();
        test_wrap_saturate();
        test_exact_max();
        test_async_reset();
        test_ramp();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
